miriscv_lsu: RTL

Load-store unit sitting directly downstream of miriscv_decode. It consumes the decoder's mem_req/mem_we/mem_size controls plus the ALU-computed address and the rs2 store data. It drives a word-addressed data-memory port with a req/ack handshake and stalls the core until each access completes. For loads it returns the byte/half/word result to the writeback mux, aligned and sign- or zero-extended.

---
 rtl/miriscv_lsu.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/miriscv_lsu.sv
// Load-store unit: turns decoder memory controls into a word-addressed req/ack
// data port access, stalls the core until completion and extends load results.
module miriscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_ack_i
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       ldata_q, ldata_d;
  logic              err_q, err_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;

  logic              size_legal;
  logic              misaligned;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;

  // Request decode: legality, alignment, lane enables and replicated store data.
  always_comb begin
    size_legal = 1'b0;
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = lsu_data_i;
    case (lsu_size_i)
      LDST_B, LDST_BU: begin
        size_legal = 1'b1;
        be_new     = 4'b0001 << lsu_addr_i[1:0];
        wdata_new  = {4{lsu_data_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        size_legal = 1'b1;
        misaligned = lsu_addr_i[0];
        be_new     = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_new  = {2{lsu_data_i[15:0]}};
      end
      LDST_W: begin
        size_legal = 1'b1;
        misaligned = (lsu_addr_i[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  // Load extraction uses the size/offset latched at request time, since the
  // core may change its address operands once the request has been accepted.
  always_comb begin
    ld_byte = data_rdata_i[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q)
      LDST_B:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LDST_BU: ld_ext = {24'h0, ld_byte};
      LDST_H:  ld_ext = {{16{ld_half[15]}}, ld_half};
      LDST_HU: ld_ext = {16'h0, ld_half};
      default: ld_ext = data_rdata_i;
    endcase
  end

  // NOTE: every _d gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    size_d  = size_q;
    off_d   = off_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lsu_req_i) begin
          if (!size_legal || misaligned) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = lsu_we_i;
            be_d    = be_new;
            addr_d  = {lsu_addr_i[31:2], 2'b00};
            wdata_d = lsu_we_i ? wdata_new : 32'h0;
            size_d  = lsu_size_i;
            off_d   = lsu_addr_i[1:0];
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // An ack on the final allowed cycle still completes the access cleanly.
        if (data_ack_i) begin
          req_d   = 1'b0;
          if (!we_q) ldata_d = ld_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the clock edge.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ldata_q <= 32'h0;
      err_q   <= 1'b0;
      size_q  <= 3'b0;
      off_q   <= 2'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
      size_q  <= size_d;
      off_q   <= off_d;
    end
  end

  assign lsu_stall_req_o = lsu_req_i & (state_q != S_DONE);
  assign lsu_err_o       = err_q;
  assign lsu_data_o      = ldata_q;
  assign data_req_o      = req_q;
  assign data_we_o       = we_q;
  assign data_be_o       = be_q;
  assign data_addr_o     = addr_q;
  assign data_wdata_o    = wdata_q;

endmodule
